// File: rtl/trace_packetizer.sv
// Purpose : turns filtered RAM-bus events into 2-bit-typed trace packets (addr/read/write/timestamp).
// Latency : 1 cycle from the qualifying bus_strobe to packet_valid.
// Backpressure: one-entry output register; a packet arriving while valid && !ready is dropped and counted.
//
// Ports:
//   mclk, reset_n                   clock, asynchronous active-low reset
//   config_addr/data/strobe         write-only config bus (flags, latencies, window lo/hi)
//   bus_strobe                      one sampled RAM clock; all bus_* qualifiers valid with it
//   bus_addr_latch/read/write       ADV / read / write cycle qualifiers
//   bus_a, bus_d, bus_nd, bus_ublb  latched address, posedge data, negedge data, byte lanes
//   packet_valid/ready/type/payload valid-ready packet output
//   burst_cycle, drop_count         current burst beat, saturating count of dropped packets
module trace_packetizer #(
   parameter int          ADDR_W     = 23,
   parameter int          DATA_W     = 16,
   parameter int          TS_W       = 23,
   parameter int          TS_SHORT_W = 5,
   parameter logic [15:0] CFG_BASE   = 16'h0001
) (
   input  logic              mclk,
   input  logic              reset_n,
   input  logic [15:0]       config_addr,
   input  logic [15:0]       config_data,
   input  logic              config_strobe,
   input  logic              bus_strobe,
   input  logic              bus_addr_latch,
   input  logic              bus_read,
   input  logic              bus_write,
   input  logic [ADDR_W-1:0] bus_a,
   input  logic [DATA_W-1:0] bus_d,
   input  logic [DATA_W-1:0] bus_nd,
   input  logic [1:0]        bus_ublb,
   output logic              packet_valid,
   input  logic              packet_ready,
   output logic [1:0]        packet_type,
   output logic [ADDR_W-1:0] packet_payload,
   output logic [7:0]        burst_cycle,
   output logic [15:0]       drop_count
);

   if (TS_SHORT_W + 2 + DATA_W != ADDR_W) begin : g_bad_widths
      $error("trace_packetizer: TS_SHORT_W+2+DATA_W must equal ADDR_W");
   end

   localparam logic [TS_W-1:0] TS5_MAX = {{(TS_W-TS_SHORT_W){1'b0}}, {TS_SHORT_W{1'b1}}};

   localparam logic [1:0] T_ADDR  = 2'b00;
   localparam logic [1:0] T_READ  = 2'b01;
   localparam logic [1:0] T_WRITE = 2'b10;
   localparam logic [1:0] T_SYNC  = 2'b11;

   logic [2:0]        flags;
   logic [3:0]        rlat, wlat;
   logic [15:0]       win_lo, win_hi;
   logic              in_win;
   logic [TS_W-1:0]   ts, ts_nxt, ts5_ext;
   logic [15:0]       win_top;
   logic              win_now, trace_any;
   logic [3:0]        rlat_eff, wlat_eff;
   logic              rd_due, wr_due;
   logic              addr_hit, wr_hit, rd_hit, sync_hit;
   logic              pkt_gen;
   logic [1:0]        pkt_type_nxt;
   logic [ADDR_W-1:0] pkt_pay_nxt;
   logic              unused_cfg;

   assign unused_cfg = ^config_data[15:8];

   // ---------------- config registers ----------------
   always_ff @(posedge mclk or negedge reset_n) begin
      if (!reset_n) begin
         flags  <= 3'd0;
         rlat   <= 4'd4;
         wlat   <= 4'd3;
         win_lo <= 16'h0000;
         win_hi <= 16'hFFFF;
      end else if (config_strobe) begin
         if (config_addr == CFG_BASE)          flags  <= config_data[2:0];
         if (config_addr == CFG_BASE + 16'd1) begin
            rlat <= config_data[3:0];
            wlat <= config_data[7:4];
         end
         if (config_addr == CFG_BASE + 16'd2)  win_lo <= config_data;
         if (config_addr == CFG_BASE + 16'd3)  win_hi <= config_data;
      end
   end

   // ---------------- packet decision ----------------
   assign trace_any = flags[0] | flags[1];
   assign win_top   = bus_a[ADDR_W-1 -: 16];
   assign win_now   = !flags[2] || ((win_top >= win_lo) && (win_top <= win_hi));
   // Zero latency behaves like one: the first data beat is always traceable.
   assign rlat_eff  = (rlat == 4'd0) ? 4'd1 : rlat;
   assign wlat_eff  = (wlat == 4'd0) ? 4'd1 : wlat;
   assign rd_due    = burst_cycle >= (8'(rlat_eff) - 8'd1);
   assign wr_due    = burst_cycle >= (8'(wlat_eff) - 8'd1);
   assign ts5_ext   = (ts > TS5_MAX) ? TS5_MAX : ts;

   assign addr_hit = trace_any && bus_addr_latch && win_now;
   assign wr_hit   = flags[1] && bus_write && in_win && wr_due;
   assign rd_hit   = flags[0] && bus_read && in_win && rd_due;
   // Sync when the short field could not carry the full delta, or before the MSB wraps.
   assign sync_hit = trace_any && (((burst_cycle == 8'd1) && (ts != ts5_ext)) || ts[TS_W-1]);

   always_comb begin
      pkt_gen      = 1'b0;
      pkt_type_nxt = T_ADDR;
      pkt_pay_nxt  = '0;
      ts_nxt       = ts;
      if (bus_strobe) begin
         ts_nxt = ts + TS_W'(1);
         if (addr_hit) begin
            pkt_gen     = 1'b1;
            pkt_pay_nxt = bus_a;
         end else if (wr_hit) begin
            pkt_gen      = 1'b1;
            pkt_type_nxt = T_WRITE;
            pkt_pay_nxt  = {ts5_ext[TS_SHORT_W-1:0], bus_ublb, bus_d};
            ts_nxt       = ts - ts5_ext;
         end else if (rd_hit) begin
            pkt_gen      = 1'b1;
            pkt_type_nxt = T_READ;
            pkt_pay_nxt  = {ts5_ext[TS_SHORT_W-1:0], bus_ublb, bus_nd};
            ts_nxt       = ts - ts5_ext;
         end else if (sync_hit) begin
            pkt_gen      = 1'b1;
            pkt_type_nxt = T_SYNC;
            pkt_pay_nxt  = ADDR_W'(ts);
            ts_nxt       = '0;
         end
      end
   end

   // ---------------- burst / window / timestamp state ----------------
   always_ff @(posedge mclk or negedge reset_n) begin
      if (!reset_n) begin
         ts          <= '0;
         burst_cycle <= 8'd0;
         in_win      <= 1'b1;
      end else if (bus_strobe) begin
         ts <= ts_nxt;
         if (bus_addr_latch) begin
            burst_cycle <= 8'd0;
            in_win      <= win_now;
         end else if ((bus_read || bus_write) && (burst_cycle != 8'hFF)) begin
            burst_cycle <= burst_cycle + 8'd1;
         end
      end
   end

   // ---------------- output register ----------------
   always_ff @(posedge mclk or negedge reset_n) begin
      if (!reset_n) begin
         packet_valid   <= 1'b0;
         packet_type    <= 2'b00;
         packet_payload <= '0;
         drop_count     <= 16'd0;
      end else if (pkt_gen && (!packet_valid || packet_ready)) begin
         packet_valid   <= 1'b1;
         packet_type    <= pkt_type_nxt;
         packet_payload <= pkt_pay_nxt;
      end else begin
         if (packet_ready) packet_valid <= 1'b0;
         // Reaching here with pkt_gen set means the register is full and stalled.
         if (pkt_gen && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
      end
   end

endmodule
